// File: rtl/alu_addsub_exec.sv
// rtl/alu_addsub_exec.sv - two-stage add/sub/compare execute pipeline with Brent-Kung adder

// 32-bit Brent-Kung prefix adder/subtractor; op_code=1 computes A-B.
module ADD_SUB_using_BK (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        op_code,
  output logic [31:0] Y
);

  // Generate/propagate, up-sweep and down-sweep of the prefix tree, then sum bits
  always_comb begin
    logic [31:0] bx;
    logic [31:0] p;
    logic [31:0] gg;
    logic [31:0] pp;
    bx = B ^ {32{op_code}};
    p  = A ^ bx;
    gg = A & bx;
    pp = p;
    // Carry-in folded into bit 0 so the tree yields carries directly
    gg[0] = gg[0] | (p[0] & op_code);
    for (int d = 0; d < 5; d++) begin
      for (int i = (2 << d) - 1; i < 32; i += (2 << d)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
        pp[i] = pp[i] & pp[i - (1 << d)];
      end
    end
    for (int d = 3; d >= 0; d--) begin
      for (int i = (3 << d) - 1; i < 32; i += (2 << d)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
        pp[i] = pp[i] & pp[i - (1 << d)];
      end
    end
    Y = p ^ {gg[30:0], op_code};
  end

endmodule

// Execute pipeline: stage 1 holds operands, stage 2 holds result and flags.
module alu_addsub_exec #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_eq,
  output logic             out_lt,
  output logic             out_ltu,
  output logic             out_ovf
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SLT  = 2'b10;

  logic             s1_valid;
  logic [1:0]       s1_op;
  logic [XLEN-1:0]  s1_a;
  logic [XLEN-1:0]  s1_b;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [XLEN-1:0]  s2_result;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_eq;
  logic             s2_lt;
  logic             s2_ltu;
  logic             s2_ovf;

  logic             s1_adv;
  logic             s2_adv;
  logic [XLEN-1:0]  sum;
  logic             eq_n;
  logic             lt_n;
  logic             ltu_n;
  logic             ovf_n;
  logic [XLEN-1:0]  result_n;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  ADD_SUB_using_BK u_adder (
    .A       (s1_a),
    .B       (s1_b),
    .op_code (s1_op != OP_ADD),
    .Y       (sum)
  );

  // Flags from the difference; when sign bits differ the sign of A alone decides ordering
  always_comb begin
    eq_n     = (sum == '0);
    lt_n     = (s1_a[XLEN-1] ^ s1_b[XLEN-1]) ? s1_a[XLEN-1] : sum[XLEN-1];
    ltu_n    = (s1_a[XLEN-1] ^ s1_b[XLEN-1]) ? s1_b[XLEN-1] : sum[XLEN-1];
    ovf_n    = 1'b0;
    result_n = sum;
    case (s1_op)
      OP_ADD: ovf_n = (s1_a[XLEN-1] == s1_b[XLEN-1]) && (sum[XLEN-1] != s1_a[XLEN-1]);
      OP_SUB: ovf_n = (s1_a[XLEN-1] != s1_b[XLEN-1]) && (sum[XLEN-1] != s1_a[XLEN-1]);
      OP_SLT: result_n = {{(XLEN-1){1'b0}}, lt_n};
      default: result_n = {{(XLEN-1){1'b0}}, ltu_n};
    endcase
  end

  // Stage 1 register: data only loads on a real op to keep idle outputs quiet
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= in_op;
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_tag <= in_tag;
      end
    end
  end

  // Stage 2 register: holds result steady while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_tag    <= '0;
      s2_eq     <= 1'b0;
      s2_lt     <= 1'b0;
      s2_ltu    <= 1'b0;
      s2_ovf    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= result_n;
        s2_tag    <= s1_tag;
        s2_eq     <= eq_n;
        s2_lt     <= lt_n;
        s2_ltu    <= ltu_n;
        s2_ovf    <= ovf_n;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_tag    = s2_tag;
  assign out_eq     = s2_eq;
  assign out_lt     = s2_lt;
  assign out_ltu    = s2_ltu;
  assign out_ovf    = s2_ovf;

endmodule

// File: tb/tb_alu_addsub_exec.sv
// tb/tb_alu_addsub_exec.sv - self-checking bench for alu_addsub_exec
module tb_alu_addsub_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_eq;
  logic        out_lt;
  logic        out_ltu;
  logic        out_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  int cyc = 0;
  bit chk_lat = 1'b0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    int          cyc;
  } ent_t;

  typedef struct {
    logic [31:0] result;
    logic        eq;
    logic        lt;
    logic        ltu;
    logic        ovf;
  } res_t;

  ent_t q[$];

  alu_addsub_exec #(.XLEN(32), .TAG_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_eq     (out_eq),
    .out_lt     (out_lt),
    .out_ltu    (out_ltu),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference semantics in plain integer arithmetic
  function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    longint sa;
    longint sb;
    longint s;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    r.eq  = (a == b);
    r.lt  = (sa < sb);
    r.ltu = (a < b);
    r.ovf = 1'b0;
    case (op)
      2'd0: begin
        s = sa + sb;
        r.result = a + b;
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'd1: begin
        s = sa - sb;
        r.result = a - b;
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'd2: r.result = {31'b0, r.lt};
      default: r.result = {31'b0, r.ltu};
    endcase
    return r;
  endfunction

  // Scoreboard compare: every output transfer, stall stability, input capture
  bit          hold = 1'b0;
  logic [31:0] h_res;
  logic [4:0]  h_tag;
  logic [3:0]  h_flags;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (hold && out_valid) begin
        check("stall_result", out_result, h_res);
        check("stall_tag", out_tag, h_tag);
        check("stall_flags", {out_eq, out_lt, out_ltu, out_ovf}, h_flags);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          ent_t e;
          res_t m;
          e = q.pop_front();
          m = model(e.op, e.a, e.b);
          n_out++;
          check("sb_result", out_result, m.result);
          check("sb_tag", out_tag, e.tag);
          check("sb_ovf", out_ovf, m.ovf);
          if (e.op != 2'd0) begin
            check("sb_eq", out_eq, m.eq);
            check("sb_lt", out_lt, m.lt);
            check("sb_ltu", out_ltu, m.ltu);
          end
          if (chk_lat) check("sb_latency", cyc - e.cyc, 2);
        end
      end
      hold    = out_valid && !out_ready;
      h_res   = out_result;
      h_tag   = out_tag;
      h_flags = {out_eq, out_lt, out_ltu, out_ovf};
      if (in_valid && in_ready) q.push_back('{in_op, in_a, in_b, in_tag, cyc});
    end
  end

  // Present one op starting just after a rising edge; returns just after its accepting edge
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    bit ok;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp_res, input logic exp_ovf,
                          input bit chk_flags, input logic exp_eq, input logic exp_lt,
                          input logic exp_ltu);
    res_t m;
    bit   seen;
    m = model(op, a, b);
    check("model_result", m.result, exp_res);
    check("model_ovf", m.ovf, exp_ovf);
    send(op, a, b, tag);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("dir_seen", seen, 1);
    check("dir_result", out_result, exp_res);
    check("dir_ovf", out_ovf, exp_ovf);
    check("dir_tag", out_tag, tag);
    if (chk_flags) check("dir_flags", {out_eq, out_lt, out_ltu}, {exp_eq, exp_lt, exp_ltu});
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_in_ready"}, in_ready, 1);
    check({name, "_outs"}, {out_result, out_tag, out_eq, out_lt, out_ltu, out_ovf}, 0);
  endtask

  logic [31:0] edge_vals [6];

  initial begin
    int   base_out;
    int   c0;
    bit   drained;
    logic [31:0] ra;
    logic [31:0] rb;

    edge_vals = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000001};
    rst = 1'b1;
    in_valid = 1'b0;
    in_op = '0;
    in_a = '0;
    in_b = '0;
    in_tag = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");
    repeat (3) @(negedge clk);
    check_idle_zero("idle");

    @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk_lat = 1'b1;
    directed(2'd0, 32'h7FFFFFFF, 32'h00000001, 5'd3, 32'h80000000, 1'b1, 1'b0, 0, 0, 0);
    directed(2'd0, 32'hFFFFFFFF, 32'h00000001, 5'd4, 32'h00000000, 1'b0, 1'b0, 0, 0, 0);
    directed(2'd1, 32'd5, 32'd5, 5'd5, 32'h0, 1'b0, 1'b1, 1, 0, 0);
    directed(2'd1, 32'h80000000, 32'h1, 5'd6, 32'h7FFFFFFF, 1'b1, 1'b1, 0, 1, 0);
    directed(2'd2, 32'hFFFFFFFF, 32'h1, 5'd7, 32'h1, 1'b0, 1'b1, 0, 1, 0);
    directed(2'd3, 32'hFFFFFFFF, 32'h1, 5'd8, 32'h0, 1'b0, 1'b1, 0, 1, 0);
    directed(2'd3, 32'h1, 32'hFFFFFFFF, 5'd9, 32'h1, 1'b0, 1'b1, 0, 0, 1);

    // Reset with two ops in flight: neither may emerge
    base_out = n_out;
    send(2'd0, 32'd10, 32'd20, 5'd10);
    send(2'd1, 32'd30, 32'd7, 5'd11);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_zero("midreset");
    repeat (5) @(negedge clk);
    check("midreset_no_out", n_out - base_out, 0);

    // Backpressure: 8 back-to-back ops, 3-cycle stall after first result
    @(posedge clk);
    #1;
    chk_lat = 1'b0;
    base_out = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(2'(i % 4), 32'h1000 * (i + 1), 32'h0F0F + i, 5'(16 + i));
        in_valid = 1'b0;
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("bp_first_seen", seen, 1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drained = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin
        drained = 1'b1;
        break;
      end
    end
    check("bp_drained", drained, 1);
    check("bp_count", n_out - base_out, 8);

    // Throughput: 100 random ops with no stalls
    @(posedge clk);
    #1;
    chk_lat = 1'b1;
    base_out = n_out;
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom();
      rb = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom();
      if (i % 10 == 0) rb = ra;
      send(2'($urandom_range(0, 3)), ra, rb, 5'(i));
    end
    in_valid = 1'b0;
    check("tp_cycles", cyc - c0, 100);
    repeat (4) @(negedge clk);
    check("tp_count", n_out - base_out, 100);
    check("tp_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_addsub_exec.md
Name: alu_addsub_exec

Overview:
- Two-stage execute pipeline for add/subtract/compare ops in the RISC-V core's ALU path.
- Stage 1 registers the operands and opcode, then drives ADD_SUB_using_BK (op_code=1 for every op except ADD).
- Stage 2 registers the adder result, derives compare and overflow flags, and presents them downstream with a valid/ready handshake.
- Full throughput: one op per cycle when downstream is not stalling.

Parameters:
- XLEN, 32, operand/result width; fixed by ADD_SUB_using_BK; only 32 supported.
- TAG_W, 5, width of the sideband tag (destination register index) carried alongside each op.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream op valid
- in_ready  output  1  stage can accept an op this cycle
- in_op  input  2  00 ADD, 01 SUB, 10 SLT, 11 SLTU
- in_a  input  XLEN  operand A
- in_b  input  XLEN  operand B
- in_tag  input  TAG_W  sideband, passed through unchanged
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_result  output  XLEN  ADD/SUB: the sum; SLT/SLTU: {31'b0, lt}
- out_tag  output  TAG_W  tag of the presented op
- out_eq  output  1  A==B (meaningful for op != ADD)
- out_lt  output  1  signed A<B (meaningful for op != ADD)
- out_ltu  output  1  unsigned A<B (meaningful for op != ADD)
- out_ovf  output  1  signed overflow of ADD/SUB; 0 for SLT/SLTU

Behaviour:
- Reset (rst=1 at a rising edge):
  - s1_valid=0, s2_valid=0.
  - All outputs driven to 0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards any in-flight ops; no partial result is emitted.
- Handshakes:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - out_valid=s2_valid.
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. It is a combinational path from out_ready; this is accepted and there is no skid buffer.
- Stage 1:
  - On s1_adv, load s1_valid<=in_valid & in_ready, along with op, a, b, tag.
  - Data registers may load don't-care values when not valid.
- Adder input: ADD_SUB_using_BK is fed from the stage-1 registers, with op_code = (s1_op != 00).
- Stage 2: on s2_adv, load s2_valid<=s1_valid and capture:
  - sum = Y.
  - eq = (Y==0).
  - lt = (a[31]^b[31]) ? a[31] : Y[31].
  - ltu = (a[31]^b[31]) ? b[31] : Y[31].
  - ovf:
    - ADD: (a[31]==b[31]) & (Y[31]!=a[31]).
    - SUB: (a[31]!=b[31]) & (Y[31]!=a[31]).
    - SLT/SLTU: 0.
  - result = sum for ADD/SUB, zero-extended lt for SLT, zero-extended ltu for SLTU.
- Latency: 2 cycles from input acceptance to out_valid with no stalls.
- Stall behaviour:
  - While out_valid & !out_ready, all out_* outputs hold stable.
  - Stage 1 holds if it is also full.
  - No op is dropped or duplicated.
- Simultaneous events:
  - Output accept and input accept in the same cycle are both honoured; full throughput is sustained.
  - An op in stage 1 moves into stage 2 in the same edge that stage 2 drains.
- Wrap-around: ADD/SUB wrap modulo 2^32; carry out is not exposed.
- Flags are computed for all ops but are only defined as meaningful where noted in Ports.

Test Plan:
- Reset then idle:
  - Expect out_valid=0, all outputs 0, in_ready=1.
  - Assert rst for 1 cycle mid-stream with 2 ops in flight → out_valid=0 the next cycle, and neither op appears.
- ADD 0x7FFFFFFF+0x00000001 with out_ready=1:
  - Expect out_valid exactly 2 cycles after acceptance.
  - Expect result 0x80000000, ovf=1, tag echoed.
  - ADD 0xFFFFFFFF+1 → result 0, ovf=0.
- SUB 5-5:
  - Expect result 0, eq=1, lt=0, ltu=0.
  - SUB 0x80000000-1 → result 0x7FFFFFFF, ovf=1.
- SLT / SLTU with a=0xFFFFFFFF, b=1:
  - SLT → result 1, lt=1, ltu=0.
  - SLTU → result 0, ltu=0, lt=1.
  - SLTU with a=1, b=0xFFFFFFFF → result 1.
- Backpressure:
  - Stream 8 ops back to back; hold out_ready=0 for 3 cycles after the first result.
  - Expect in_ready=0 once both stages are full and outputs stable during the stall.
  - All 8 results arrive in order with correct tags.
- Throughput:
  - out_ready=1 and in_valid=1 continuously with 100 random ops.
  - Expect one result per cycle after 2-cycle fill; scoreboard matches a reference model.
